fft_frame_serializer: RTL and testbench

//  Downstream stage of the parallel radix-2 DIF FFT core. Captures a whole N-point

---
 rtl/fft_frame_serializer.sv | 153 +++++++++++++++
 tb/tb_fft_frame_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
// Ping-pong frame store behind the parallel FFT core: captures whole frames on
// frame_valid and replays them one bin per beat on a valid/ready stream.
module fft_frame_serializer #(
    parameter int DATA_WIDTH = 11,
    parameter int POW        = 3,
    parameter int OUT_WIDTH  = DATA_WIDTH + 2*POW,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [(2**POW)-1:0][OUT_WIDTH-1:0] frame_r,
    input  logic [(2**POW)-1:0][OUT_WIDTH-1:0] frame_i,
    input  logic                               frame_valid,
    output logic signed [OUT_WIDTH-1:0]        m_data_r,
    output logic signed [OUT_WIDTH-1:0]        m_data_i,
    output logic [POW-1:0]                     m_index,
    output logic                               m_sop,
    output logic                               m_eop,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               ovf,
    input  logic                               ovf_clr,
    output logic [CNT_WIDTH-1:0]               drop_cnt
);
    localparam int              N        = 2**POW;
    localparam int              WORD_W   = 2*OUT_WIDTH;
    localparam logic [POW-1:0]  LAST_IDX = POW'(N-1);

    // Bank-level state
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [POW-1:0]       r_idx;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    // Frame storage, one {real, imag} word per bin per bank
    logic [WORD_W-1:0]    r_buf [2][N];

    logic [WORD_W-1:0]    w_bin [N];
    logic [WORD_W-1:0]    w_rd_word;

    logic                 w_valid;
    logic                 w_fire;
    logic                 w_last_beat;
    logic                 w_capture;
    logic                 w_drop;
    logic                 w_cnt_sat;

    logic [1:0]           w_full_next;
    logic                 w_wr_bank_next;
    logic                 w_rd_bank_next;
    logic [POW-1:0]       w_idx_next;
    logic                 w_ovf_next;
    logic [CNT_WIDTH-1:0] w_drop_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign w_bin[gi] = {frame_r[gi], frame_i[gi]};
        end
    endgenerate

    assign w_valid     = r_full[r_rd_bank];
    assign w_fire      = w_valid & m_ready;
    assign w_last_beat = w_fire & (r_idx == LAST_IDX);

    // A frame may land in the bank whose last beat leaves this very cycle.
    assign w_capture = frame_valid &
                       (~r_full[r_wr_bank] | (w_last_beat & (r_wr_bank == r_rd_bank)));
    assign w_drop    = frame_valid & ~w_capture;
    assign w_cnt_sat = &r_drop_cnt;

    always_comb begin
        w_full_next     = r_full;
        w_wr_bank_next  = r_wr_bank;
        w_rd_bank_next  = r_rd_bank;
        w_idx_next      = r_idx;
        w_ovf_next      = r_ovf;
        w_drop_cnt_next = r_drop_cnt;

        if (w_fire) begin
            if (w_last_beat) begin
                w_idx_next     = '0;
                w_rd_bank_next = ~r_rd_bank;
            end else begin
                w_idx_next = r_idx + 1'b1;
            end
        end

        // Release first, so a same-cycle capture into that bank keeps it full.
        if (w_last_beat) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_capture) begin
            w_full_next[r_wr_bank] = 1'b1;
            w_wr_bank_next         = ~r_wr_bank;
        end

        if (w_drop) begin
            w_ovf_next = 1'b1;
            if (!w_cnt_sat) begin
                w_drop_cnt_next = r_drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_full     <= w_full_next;
            r_wr_bank  <= w_wr_bank_next;
            r_rd_bank  <= w_rd_bank_next;
            r_idx      <= w_idx_next;
            r_ovf      <= w_ovf_next;
            r_drop_cnt <= w_drop_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    r_buf[b][k] <= '0;
                end
            end
        end else if (w_capture) begin
            for (int k = 0; k < N; k++) begin
                r_buf[r_wr_bank][k] <= w_bin[k];
            end
        end
    end

    assign w_rd_word = r_buf[r_rd_bank][r_idx];

    assign m_data_r = $signed(w_rd_word[WORD_W-1:OUT_WIDTH]);
    assign m_data_i = $signed(w_rd_word[OUT_WIDTH-1:0]);
    assign m_index  = r_idx;
    assign m_sop    = (r_idx == '0);
    assign m_eop    = (r_idx == LAST_IDX);
    assign m_valid  = w_valid;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, random traffic, counter saturation.
module tb_fft_frame_serializer;
    localparam int POW = 3;
    localparam int N   = 8;
    localparam int DW  = 11;
    localparam int W   = DW + 2*POW;
    localparam int CW  = 16;
    localparam int CNT_MAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [N-1:0][W-1:0]    frame_r;
    logic [N-1:0][W-1:0]    frame_i;
    logic                   frame_valid;
    logic signed [W-1:0]    m_data_r;
    logic signed [W-1:0]    m_data_i;
    logic [POW-1:0]         m_index;
    logic                   m_sop;
    logic                   m_eop;
    logic                   m_valid;
    logic                   m_ready;
    logic                   ovf;
    logic                   ovf_clr;
    logic [CW-1:0]          drop_cnt;

    fft_frame_serializer #(
        .DATA_WIDTH (DW),
        .POW        (POW),
        .OUT_WIDTH  (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_r     (frame_r),
        .frame_i     (frame_i),
        .frame_valid (frame_valid),
        .m_data_r    (m_data_r),
        .m_data_i    (m_data_i),
        .m_index     (m_index),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .drop_cnt    (drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two whole frames plus the beat number within the head.
    logic [N*W-1:0] q_r[$];
    logic [N*W-1:0] q_i[$];
    int  mdl_idx = 0;
    bit  mdl_ovf = 1'b0;
    int  mdl_cnt = 0;
    bit  mdl_fire, mdl_last, mdl_cap;

    always @(posedge clk) begin
        if (rst) begin
            q_r.delete();
            q_i.delete();
            mdl_idx = 0;
            mdl_ovf = 1'b0;
            mdl_cnt = 0;
        end else begin
            mdl_fire = (q_r.size() > 0) && m_ready;
            mdl_last = mdl_fire && (mdl_idx == N-1);
            mdl_cap  = frame_valid && ((q_r.size() < 2) || mdl_last);
            if (mdl_fire) mdl_idx = mdl_last ? 0 : mdl_idx + 1;
            if (mdl_last) begin
                void'(q_r.pop_front());
                void'(q_i.pop_front());
            end
            if (mdl_cap) begin
                q_r.push_back(frame_r);
                q_i.push_back(frame_i);
            end
            if (frame_valid && !mdl_cap) begin
                mdl_ovf = 1'b1;
                if (mdl_cnt < CNT_MAX) mdl_cnt++;
            end else if (ovf_clr) begin
                mdl_ovf = 1'b0;
            end
        end
    end

    logic signed [W-1:0] e_r, e_i;

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid",  m_valid,  (q_r.size() > 0) ? 1 : 0);
            check("m_index",  m_index,  mdl_idx);
            check("m_sop",    m_sop,    (mdl_idx == 0) ? 1 : 0);
            check("m_eop",    m_eop,    (mdl_idx == N-1) ? 1 : 0);
            check("ovf",      ovf,      mdl_ovf ? 1 : 0);
            check("drop_cnt", drop_cnt, mdl_cnt);
            if (q_r.size() > 0) begin
                e_r = q_r[0][mdl_idx*W +: W];
                e_i = q_i[0][mdl_idx*W +: W];
                check("m_data_r", m_data_r, e_r);
                check("m_data_i", m_data_i, e_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lin_frame();
        for (int k = 0; k < N; k++) begin
            frame_r[k] = W'(10*k);
            frame_i[k] = W'(-k);
        end
    endtask

    task automatic set_rand_frame();
        for (int k = 0; k < N; k++) begin
            frame_r[k] = W'($urandom);
            frame_i[k] = W'($urandom);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int  fires;
    bit  found;

    initial begin
        rst = 1'b1; frame_valid = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        frame_r = '0; frame_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data_r", m_data_r, 0);
        check("rst_m_data_i", m_data_i, 0);
        check("rst_m_index", m_index, 0);
        check("rst_m_sop", m_sop, 1);
        check("rst_m_eop", m_eop, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // 1: single frame, ready always high
        set_lin_frame(); frame_valid = 1'b1; m_ready = 1'b1;
        tick(); frame_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check("t1_valid", m_valid, 1);
            check("t1_index", m_index, k);
            check("t1_r", m_data_r, 10*k);
            check("t1_i", m_data_i, -k);
            check("t1_sop", m_sop, (k == 0) ? 1 : 0);
            check("t1_eop", m_eop, (k == N-1) ? 1 : 0);
        end
        @(negedge clk);
        check("t1_idle", m_valid, 0);

        // 2: ready alternates 1,0,1,0...
        set_lin_frame(); frame_valid = 1'b1; m_ready = 1'b1;
        tick(); frame_valid = 1'b0;
        fires = 0;
        for (int cyc = 0; cyc < 40 && fires < N; cyc++) begin
            m_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (m_valid && m_ready) begin
                check("t2_index", m_index, fires);
                check("t2_r", m_data_r, 10*fires);
                check("t2_i", m_data_i, -fires);
                fires++;
            end
            tick();
        end
        check("t2_beats", fires, N);
        @(negedge clk);
        check("t2_idle", m_valid, 0);

        // 3: three back-to-back frames with the sink stalled: third dropped
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            set_rand_frame(); frame_valid = 1'b1;
            tick();
        end
        frame_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("t3_ovf", ovf, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        m_ready = 1'b1;
        repeat (2*N + 1) tick();
        @(negedge clk);
        check("t3_idle", m_valid, 0);

        // 4: both banks full, new frame arrives on A's final beat
        m_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            set_rand_frame(); frame_valid = 1'b1;
            tick();
        end
        frame_valid = 1'b0;
        m_ready = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (m_valid && m_index == 3'd6) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_reach_beat6", found, 1);
        tick();
        set_rand_frame(); frame_valid = 1'b1;
        tick(); frame_valid = 1'b0;
        @(negedge clk);
        check("t4_drop_cnt", drop_cnt, 1);
        check("t4_next_valid", m_valid, 1);
        check("t4_next_index", m_index, 0);
        repeat (2*N + 1) tick();
        @(negedge clk);
        check("t4_idle", m_valid, 0);

        // 5: reset three beats into a frame
        set_lin_frame(); frame_valid = 1'b1; m_ready = 1'b1;
        tick(); frame_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t5_valid", m_valid, 0);
        check("t5_ovf", ovf, 0);
        check("t5_drop_cnt", drop_cnt, 0);
        check("t5_index", m_index, 0);
        check("t5_sop", m_sop, 1);
        check("t5_data_r", m_data_r, 0);
        set_lin_frame(); frame_valid = 1'b1;
        tick(); frame_valid = 1'b0;
        @(negedge clk);
        check("t5_new_index", m_index, 0);
        check("t5_new_sop", m_sop, 1);
        @(negedge clk);
        check("t5_new_r1", m_data_r, 10);
        repeat (N + 1) tick();

        // 6: ovf_clr coinciding with a drop, then alone
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            set_rand_frame(); frame_valid = 1'b1;
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        frame_valid = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        check("t6_ovf_held", ovf, 1);
        check("t6_drop_cnt", drop_cnt, 2);
        ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        @(negedge clk);
        check("t6_ovf_clr", ovf, 0);
        check("t6_drop_kept", drop_cnt, 2);
        m_ready = 1'b1;
        repeat (2*N + 1) tick();

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            set_rand_frame();
            frame_valid = ($urandom_range(0, 4) == 0);
            m_ready     = ($urandom_range(0, 3) != 0);
            ovf_clr     = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; frame_valid = 1'b0; ovf_clr = 1'b0;

        // Drop counter saturation
        rst = 1'b1;
        tick(); rst = 1'b0;
        m_ready = 1'b0; frame_valid = 1'b1;
        repeat (CNT_MAX + 4) tick();
        frame_valid = 1'b0;
        @(negedge clk);
        check("sat_drop_cnt", drop_cnt, CNT_MAX);
        check("sat_ovf", ovf, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
